// File: rtl/writeback_stage.sv
// writeback_stage: MEM/WB register with load formatting, r0 write suppression and retire counter.
// Define WB_FORWARD_EN to add register-file bypass match outputs.
module writeback_stage #(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   in_valid,
  input  logic                   stall,
  input  logic                   flush,
  input  logic [31:0]            in_alu_result,
  input  logic [31:0]            in_mem_data,
  input  logic [31:0]            in_pc_plus4,
  input  logic [4:0]             in_rt,
  input  logic [4:0]             in_rd,
  input  logic [1:0]             in_reg_dst,
  input  logic [1:0]             in_mem_to_reg,
  input  logic [1:0]             in_load_size,
  input  logic                   in_load_signed,
  input  logic                   in_reg_write,
  output logic [31:0]            WriteData,
  output logic [4:0]             WriteRegister,
  output logic                   RegWrite,
  output logic                   wb_valid,
`ifdef WB_FORWARD_EN
  input  logic [4:0]             fwd_reg1,
  input  logic [4:0]             fwd_reg2,
  output logic                   fwd_match1,
  output logic                   fwd_match2,
  output logic [31:0]            fwd_data,
`else
`endif
  output logic [COUNT_WIDTH-1:0] retired_count
);
  logic                   valid_q, valid_d;
  logic                   rw_q, rw_d;
  logic [4:0]             dst_q, dst_d;
  logic [31:0]            data_q, data_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [7:0]             lane;
  logic [15:0]            half;
  logic [31:0]            load, fmt;
  logic [4:0]             dst;
  logic                   capture;
  always_comb begin
    lane    = in_mem_data[{in_alu_result[1:0], 3'b000} +: 8];
    half    = in_alu_result[1] ? in_mem_data[31:16] : in_mem_data[15:0];
    load    = in_load_size == 2'b10 ? {{24{in_load_signed & lane[7]}}, lane} :
              in_load_size == 2'b01 ? {{16{in_load_signed & half[15]}}, half} : in_mem_data;
    fmt     = in_mem_to_reg == 2'b01 ? load : in_mem_to_reg == 2'b10 ? in_pc_plus4 : in_alu_result;
    dst     = in_reg_dst == 2'b01 ? in_rd : in_reg_dst == 2'b10 ? 5'd31 : in_rt;
    capture = !flush && !stall;
    valid_d = flush ? 1'b0 : stall ? valid_q : in_valid;
    rw_d    = capture ? in_reg_write : rw_q;
    dst_d   = capture ? dst : dst_q;
    data_d  = capture ? fmt : data_q;
    // A held instruction retires only when it leaves; flush kills the incoming one, not this one
    cnt_d   = cnt_q + COUNT_WIDTH'(valid_q & ~stall);
  end
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      valid_q <= 1'b0;
      rw_q    <= 1'b0;
      dst_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      rw_q    <= rw_d;
      dst_q   <= dst_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end
  assign WriteData     = data_q;
  assign WriteRegister = dst_q;
  assign RegWrite      = valid_q & rw_q & (dst_q != 5'd0);
  assign wb_valid      = valid_q;
  assign retired_count = cnt_q;
`ifdef WB_FORWARD_EN
  assign fwd_match1 = RegWrite & (WriteRegister == fwd_reg1);
  assign fwd_match2 = RegWrite & (WriteRegister == fwd_reg2);
  assign fwd_data   = WriteData;
`else
`endif
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: randomized and directed checks of writeback_stage against a behavioural model.
module tb_writeback_stage;
  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        in_valid = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [31:0] in_alu_result = '0, in_mem_data = '0, in_pc_plus4 = '0;
  logic [4:0]  in_rt = '0, in_rd = '0;
  logic [1:0]  in_reg_dst = '0, in_mem_to_reg = '0, in_load_size = '0;
  logic        in_load_signed = 1'b0, in_reg_write = 1'b0;
  logic [31:0] WriteData;
  logic [4:0]  WriteRegister;
  logic        RegWrite, wb_valid;
  logic [31:0] retired_count;
`ifdef WB_FORWARD_EN
  logic [4:0]  fwd_reg1 = '0, fwd_reg2 = '0;
  logic        fwd_match1, fwd_match2;
  logic [31:0] fwd_data;
`endif
  int n_tests = 0, n_fail = 0;
  logic        m_valid = 0, m_rw = 0;
  logic [4:0]  m_dst = 0;
  logic [31:0] m_data = 0, m_cnt = 0;
  logic [31:0] rf [32];

  writeback_stage #(.COUNT_WIDTH(32)) dut (
    .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .stall(stall), .flush(flush),
    .in_alu_result(in_alu_result), .in_mem_data(in_mem_data), .in_pc_plus4(in_pc_plus4),
    .in_rt(in_rt), .in_rd(in_rd), .in_reg_dst(in_reg_dst), .in_mem_to_reg(in_mem_to_reg),
    .in_load_size(in_load_size), .in_load_signed(in_load_signed), .in_reg_write(in_reg_write),
    .WriteData(WriteData), .WriteRegister(WriteRegister), .RegWrite(RegWrite), .wb_valid(wb_valid),
`ifdef WB_FORWARD_EN
    .fwd_reg1(fwd_reg1), .fwd_reg2(fwd_reg2), .fwd_match1(fwd_match1), .fwd_match2(fwd_match2),
    .fwd_data(fwd_data),
`endif
    .retired_count(retired_count)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) if (RegWrite) rf[WriteRegister] <= WriteData;

  function automatic logic [31:0] ref_data(input logic [1:0] mtr, sz, input logic sg,
                                           input logic [31:0] alu, mem, pc);
    int unsigned off, v;
    off = alu % 4;
    if (mtr == 2) return pc;
    if (mtr != 1) return alu;
    if (sz == 2) begin
      v = (mem / (1 << (8 * off))) % 256;
      if (sg && v >= 128) v = v + 32'hFFFF_FF00;
      return v;
    end
    if (sz == 1) begin
      v = (off >= 2) ? mem / 65536 : mem % 65536;
      if (sg && v >= 32768) v = v + 32'hFFFF_0000;
      return v;
    end
    return mem;
  endfunction

  function automatic logic [4:0] ref_dst(input logic [1:0] sel, input logic [4:0] rt, rd);
    return sel == 1 ? rd : sel == 2 ? 5'd31 : rt;
  endfunction

  task automatic drive(input logic v, rw, input logic [1:0] dsel, mtr, sz, input logic sg,
                       input logic [31:0] alu, mem, pc, input logic [4:0] rt, rd);
    in_valid = v; in_reg_write = rw; in_reg_dst = dsel; in_mem_to_reg = mtr;
    in_load_size = sz; in_load_signed = sg; in_alu_result = alu; in_mem_data = mem;
    in_pc_plus4 = pc; in_rt = rt; in_rd = rd;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic step();
    @(posedge Clk);
    if (Reset) begin
      m_valid = 0; m_rw = 0; m_dst = 0; m_data = 0; m_cnt = 0;
    end else begin
      if (m_valid && !stall) m_cnt++;
      if (flush) m_valid = 0;
      else if (!stall) begin
        m_valid = in_valid; m_rw = in_reg_write;
        m_dst = ref_dst(in_reg_dst, in_rt, in_rd);
        m_data = ref_data(in_mem_to_reg, in_load_size, in_load_signed, in_alu_result, in_mem_data, in_pc_plus4);
      end
    end
    @(negedge Clk);
  endtask

  task automatic test_reset();
    #3;
    n_tests++;
    if ({RegWrite, wb_valid, WriteRegister, WriteData, retired_count} !== '0) begin
      n_fail++;
      $display("FAIL reset: rw=%b v=%b wr=%0d wd=%h cnt=%0d, all required 0", RegWrite, wb_valid, WriteRegister, WriteData, retired_count);
    end
    step(); step();
    Reset = 1'b0;
  endtask

  task automatic test_add();
    drive(1, 1, 2'b01, 2'b00, 0, 0, 32'h1234, 32'hAAAA_5555, 32'h100, 5'd2, 5'd5);
    step();
    n_tests++;
    if (RegWrite !== 1 || WriteRegister !== 5 || WriteData !== 32'h1234 || retired_count !== 0) begin
      n_fail++;
      $display("FAIL add_capture: rw=%b wr=%0d wd=%h cnt=%0d, required 1/5/00001234/0", RegWrite, WriteRegister, WriteData, retired_count);
    end
    idle();
    step();
    n_tests++;
    if (rf[5] !== 32'h1234 || retired_count !== 1 || RegWrite !== 0) begin
      n_fail++;
      $display("FAIL add_write: r5=%h cnt=%0d rw=%b, required 00001234/1/0", rf[5], retired_count, RegWrite);
    end
  endtask

  task automatic test_loads();
    logic [1:0]  sz  [4] = '{2'b10, 2'b10, 2'b01, 2'b01};
    logic        sg  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] off [4] = '{2, 3, 2, 1};
    logic [31:0] exp [4] = '{32'hFFFF_FFFF, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01};
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 2'b00, 2'b01, sz[i], sg[i], 32'h1000_0000 | off[i], 32'h80FF_7F01, 0, 5'd3, 5'd9);
      step();
      n_tests++;
      if (WriteData !== exp[i] || WriteRegister !== 3 || RegWrite !== 1) begin
        n_fail++;
        $display("FAIL load_%0d: wd=%h wr=%0d rw=%b, required %h/3/1", i, WriteData, WriteRegister, RegWrite, exp[i]);
      end
    end
    idle();
    step();
  endtask

  task automatic test_jal_r0();
    logic [31:0] c;
    drive(1, 1, 2'b10, 2'b10, 0, 0, 32'h55, 32'h66, 32'h0040_0010, 5'd4, 5'd6);
    step();
    n_tests++;
    if (WriteRegister !== 31 || WriteData !== 32'h0040_0010 || RegWrite !== 1) begin
      n_fail++;
      $display("FAIL jal: wr=%0d wd=%h rw=%b, required 31/00400010/1", WriteRegister, WriteData, RegWrite);
    end
    c = m_cnt;
    drive(1, 1, 2'b00, 2'b00, 0, 0, 32'h77, 0, 0, 5'd0, 5'd8);
    step();
    n_tests++;
    if (RegWrite !== 0 || wb_valid !== 1 || WriteRegister !== 0 || retired_count !== c + 1) begin
      n_fail++;
      $display("FAIL r0_write: rw=%b v=%b wr=%0d cnt=%0d, required 0/1/0/%0d", RegWrite, wb_valid, WriteRegister, retired_count, c + 1);
    end
    idle();
    step();
    n_tests++;
    if (retired_count !== c + 2) begin
      n_fail++;
      $display("FAIL r0_retire: cnt=%0d, required %0d", retired_count, c + 2);
    end
  endtask

  task automatic test_stall_flush();
    logic [31:0] c;
    drive(1, 1, 2'b01, 2'b00, 0, 0, 32'hCAFE_0009, 0, 0, 5'd1, 5'd9);
    step();
    c = m_cnt;
    stall = 1;
    drive(1, 1, 2'b01, 2'b00, 0, 0, 32'h1111_1111, 0, 0, 5'd1, 5'd12);
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++;
      if (RegWrite !== 1 || WriteRegister !== 9 || WriteData !== 32'hCAFE_0009 || retired_count !== c) begin
        n_fail++;
        $display("FAIL stall_%0d: rw=%b wr=%0d wd=%h cnt=%0d, required 1/9/cafe0009/%0d", i, RegWrite, WriteRegister, WriteData, retired_count, c);
      end
    end
    flush = 1;
    step();
    n_tests++;
    if (wb_valid !== 0 || RegWrite !== 0 || retired_count !== c) begin
      n_fail++;
      $display("FAIL flush_stall: v=%b rw=%b cnt=%0d, required 0/0/%0d", wb_valid, RegWrite, retired_count, c);
    end
    flush = 0; stall = 0;
    step();
    n_tests++;
    if (wb_valid !== 1 || WriteRegister !== 12 || retired_count !== c) begin
      n_fail++;
      $display("FAIL resume_capture: v=%b wr=%0d cnt=%0d, required 1/12/%0d", wb_valid, WriteRegister, retired_count, c);
    end
    idle();
    step();
    n_tests++;
    if (retired_count !== c + 1) begin
      n_fail++;
      $display("FAIL resume_count: cnt=%0d, required %0d", retired_count, c + 1);
    end
  endtask

  task automatic test_random();
    logic exp_rw;
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1), 2'($urandom), 2'($urandom), 2'($urandom),
            $urandom_range(0, 1), $urandom, $urandom, $urandom, 5'($urandom_range(0, 7)), 5'($urandom));
      stall = $urandom_range(0, 5) == 0;
      flush = $urandom_range(0, 6) == 0;
      step();
      exp_rw = m_valid && m_rw && m_dst != 0;
      n_tests++;
      if (wb_valid !== m_valid || RegWrite !== exp_rw || WriteRegister !== m_dst || WriteData !== m_data || retired_count !== m_cnt) begin
        n_fail++;
        $display("FAIL random_%0d: v=%b rw=%b wr=%0d wd=%h cnt=%0d, required %b/%b/%0d/%h/%0d", i,
                 wb_valid, RegWrite, WriteRegister, WriteData, retired_count, m_valid, exp_rw, m_dst, m_data, m_cnt);
      end
    end
    stall = 0; flush = 0;
    idle();
    step();
  endtask

`ifdef WB_FORWARD_EN
  task automatic test_forward();
    drive(1, 1, 2'b01, 2'b00, 0, 0, 32'h0BAD_F00D, 0, 0, 5'd2, 5'd7);
    fwd_reg1 = 7; fwd_reg2 = 0;
    step();
    n_tests++;
    if (fwd_match1 !== 1 || fwd_match2 !== 0 || fwd_data !== 32'h0BAD_F00D) begin
      n_fail++;
      $display("FAIL forward: m1=%b m2=%b fd=%h, required 1/0/0badf00d", fwd_match1, fwd_match2, fwd_data);
    end
    idle();
    step();
  endtask
`endif

  task automatic test_reset_mid();
    logic [31:0] old;
    drive(1, 1, 2'b00, 2'b01, 2'b00, 0, 32'h2000_0000, 32'hDEAD_BEEF, 0, 5'd5, 5'd0);
    step();
    n_tests++;
    if (RegWrite !== 1 || WriteData !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL reset_mid_load: rw=%b wd=%h, required 1/deadbeef", RegWrite, WriteData);
    end
    old = rf[5];
    #2 Reset = 1'b1;
    #1;
    n_tests++;
    if ({RegWrite, wb_valid, WriteRegister, WriteData, retired_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: rw=%b v=%b wr=%0d wd=%h cnt=%0d, all required 0", RegWrite, wb_valid, WriteRegister, WriteData, retired_count);
    end
    step();
    n_tests++;
    if (rf[5] !== old) begin
      n_fail++;
      $display("FAIL reset_mid_rf: r5=%h, required %h", rf[5], old);
    end
    Reset = 1'b0;
    idle();
    step();
  endtask

  initial begin
    test_reset();
    test_add();
    test_loads();
    test_jal_r0();
    test_stall_flush();
    test_random();
`ifdef WB_FORWARD_EN
    test_forward();
`endif
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- MEM/WB pipeline register plus write-back formatting for the pipelined MIPS datapath.
- Sits directly upstream of the 32x32 register file. It drives that file's WriteData, WriteRegister and RegWrite inputs on the same Clk.
- Selects the write-back source, extracts and extends sub-word loads, chooses the destination register, suppresses writes to r0, and counts retired instructions.

Parameters:
- COUNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
- Clk  in  1  clock; the stage and the register file both act on the positive edge.
- Reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  MEM stage holds a real instruction.
- stall  in  1  hold stage contents.
- flush  in  1  discard the incoming instruction.
- in_alu_result  in  32  ALU result; bits [1:0] are the load byte offset.
- in_mem_data  in  32  raw data-memory word.
- in_pc_plus4  in  32  link address.
- in_rt  in  5  rt field.
- in_rd  in  5  rd field.
- in_reg_dst  in  2  destination select: 00 rt, 01 rd, 10 r31, 11 rt.
- in_mem_to_reg  in  2  data source select: 00 ALU, 01 memory, 10 pc+4, 11 ALU.
- in_load_size  in  2  00 word, 01 halfword, 10 byte, 11 word.
- in_load_signed  in  1  1 = sign-extend, 0 = zero-extend.
- in_reg_write  in  1  instruction writes a register.
- WriteData  out  32  to register file.
- WriteRegister  out  5  to register file.
- RegWrite  out  1  to register file.
- wb_valid  out  1  stage holds a valid instruction.
- retired_count  out  COUNT_WIDTH  retired-instruction count.

Behaviour:
- Reset (async, asserted): all stage registers 0, wb_valid 0, retired_count 0. Consequently WriteData 0, WriteRegister 0, RegWrite 0. Reset mid-operation drops the held instruction; no write occurs.
- Stage register update on posedge Clk, priority flush > stall > capture:
  - flush=1: wb_valid <= 0; data fields don't-care.
  - stall=1: all stage registers hold.
  - otherwise: capture all in_* fields; wb_valid <= in_valid.
- Destination and source selection are applied at capture. Stored fields are the resolved 5-bit destination and the 32-bit formatted data.
- Load formatting applies only when in_mem_to_reg=01. Byte lanes are little-endian; off = in_alu_result[1:0].
  - byte: lane off (off 0 = bits [7:0]), extended to 32 bits.
  - halfword: off[1] selects [15:0] or [31:16]; off[0] is ignored. Result is extended to 32 bits.
  - word: used as-is.
- Output timing: WriteData, WriteRegister and RegWrite are driven combinationally from the stage registers only, with no combinational path from in_*.
  - An instruction captured at edge N is written into the register file at edge N+1 (one-cycle latency).
- RegWrite = wb_valid & stored reg_write & (WriteRegister != 0). A write to r0 never asserts RegWrite.
- While stalled with a valid held instruction, RegWrite stays asserted and the same idempotent write repeats each cycle.
- retired_count increments by 1 on each posedge where wb_valid=1 and stall=0. This holds regardless of flush, because flush only kills the incoming instruction. The counter wraps modulo 2^COUNT_WIDTH.
- Simultaneous flush and stall: flush wins; wb_valid <= 0. retired_count does not increment that edge, since stall=1.

Optional Feature:
- Macro WB_FORWARD_EN.
- When defined, the block adds these ports:
  - fwd_reg1  in  5
  - fwd_reg2  in  5
  - fwd_match1  out  1
  - fwd_match2  out  1
  - fwd_data  out  32
- fwd_matchX = RegWrite & (WriteRegister == fwd_regX), purely combinational. fwd_data = WriteData.
- Upstream bypass muxes use these outputs to cover same-cycle write/read of the register file.
- When not defined, these ports are absent and all other behaviour is identical.

Test Plan:
- Reset mid-stream with a valid lw held -> RegWrite, WriteData, WriteRegister, wb_valid and retired_count all 0 immediately. The register file is unchanged at the next edge.
- add, rd=5, ALU=0x0000_1234, reg_write=1, captured at edge 1 -> RegWrite=1 and WriteRegister=5 during the following cycle. The register file holds 0x1234 in r5 after edge 2. retired_count=1.
- lb signed, mem=0x80FF_7F01, off=2 -> WriteData=0xFFFF_FFFF.
  - lbu off=3 -> 0x0000_0080.
  - lh signed off=2 -> 0xFFFF_80FF.
  - lhu off=1 -> 0x0000_7F01.
- jal: reg_dst=10, mem_to_reg=10, pc+4=0x0040_0010 -> WriteRegister=31, WriteData=0x0040_0010. Separately, any write with destination 0 -> RegWrite=0, and retired_count still increments.
- Stall for 3 cycles with valid held, then flush and stall together -> outputs are held and retired_count does not increment while stalled. wb_valid=0 after the flush edge. retired_count resumes counting at the first unstalled valid edge.
- WB_FORWARD_EN build, stage writes r7 and fwd_reg1=7, fwd_reg2=0 -> fwd_match1=1, fwd_match2=0, fwd_data=WriteData. A build without the macro compiles with the ports absent.
